// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
//
// Per-shot timing generator for the pulser / acquisition chain. A start request
// drives the positive pulser (pon) and then the damping drive (poff), waits a
// programmable delay, issues a one-cycle en_acquisition strobe and waits for the
// acquisition stage to finish (acq_busy rises and falls again). After an
// inter-shot gap the shot repeats until the programmed shot count is reached.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   start          level; a high sample while idle begins a sequence
//   abort          synchronous; returns to idle from any state
//   t_pon          pon duration in cycles        (0 behaves as 1)
//   t_poff         poff duration in cycles       (0 behaves as 1)
//   t_delay        poff end -> strobe, in cycles (0 behaves as 1)
//   t_gap          acquisition end -> next shot  (0 behaves as 1)
//   n_shots        shots per sequence            (0 behaves as 1)
//   acq_busy       en_write fed back from the acquisition stage
//   pon            positive pulser drive
//   poff           damping drive
//   en_acquisition one-cycle acquisition strobe
//   busy           high whenever the sequencer is not idle
//   shot_idx       0-based index of the current shot
//   done           one-cycle pulse on normal sequence completion
//
// All outputs are registered. Timing inputs are captured into shadow registers
// on the edge that leaves idle, so changes mid-sequence have no effect.
// -----------------------------------------------------------------------------
module pulse_sequencer #(
  parameter int CNTW  = 16,
  parameter int SHOTW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNTW-1:0]  t_pon,
  input  logic [CNTW-1:0]  t_poff,
  input  logic [CNTW-1:0]  t_delay,
  input  logic [CNTW-1:0]  t_gap,
  input  logic [SHOTW-1:0] n_shots,
  input  logic             acq_busy,
  output logic             pon,
  output logic             poff,
  output logic             en_acquisition,
  output logic             busy,
  output logic [SHOTW-1:0] shot_idx,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PON,
    S_POFF,
    S_DELAY,
    S_ARM,
    S_WAIT,
    S_GAP
  } state_e;

  // A timed state lasting max(T,1) cycles loads its down-counter with
  // max(T,1)-1 and leaves when the counter reads zero.
  function automatic logic [CNTW-1:0] load_val(input logic [CNTW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             pon_q, pon_d;
  logic             poff_q, poff_d;
  logic             en_acq_q, en_acq_d;
  logic             busy_q, busy_d;
  logic [SHOTW-1:0] shot_idx_q, shot_idx_d;
  logic             done_q, done_d;

  // Shadow copies of the timing inputs, held as counter load values.
  logic [CNTW-1:0]  sh_pon_q, sh_pon_d;
  logic [CNTW-1:0]  sh_poff_q, sh_poff_d;
  logic [CNTW-1:0]  sh_delay_q, sh_delay_d;
  logic [CNTW-1:0]  sh_gap_q, sh_gap_d;
  logic [SHOTW-1:0] sh_last_q, sh_last_d;   // index of the final shot

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    shot_idx_d = shot_idx_q;
    sh_pon_d   = sh_pon_q;
    sh_poff_d  = sh_poff_q;
    sh_delay_d = sh_delay_q;
    sh_gap_d   = sh_gap_q;
    sh_last_d  = sh_last_q;
    pon_d      = 1'b0;
    poff_d     = 1'b0;
    en_acq_d   = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PON;
          cnt_d      = load_val(t_pon);
          pon_d      = 1'b1;
          shot_idx_d = '0;
          sh_pon_d   = load_val(t_pon);
          sh_poff_d  = load_val(t_poff);
          sh_delay_d = load_val(t_delay);
          sh_gap_d   = load_val(t_gap);
          sh_last_d  = (n_shots == '0) ? '0 : n_shots - 1'b1;
        end
      end

      // pon hands over directly to poff on the same edge: no overlap and
      // no dead cycle between the two drives.
      S_PON: begin
        if (cnt_q == '0) begin
          state_d = S_POFF;
          cnt_d   = sh_poff_q;
          poff_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          pon_d = 1'b1;
        end
      end

      S_POFF: begin
        if (cnt_q == '0) begin
          state_d = S_DELAY;
          cnt_d   = sh_delay_q;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          poff_d = 1'b1;
        end
      end

      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d  = S_ARM;
          en_acq_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // The acquisition stage may already be busy while the strobe is out.
      S_ARM: begin
        state_d = S_WAIT;
        if (acq_busy) seen_d = 1'b1;
      end

      // Wait for a full busy high->low cycle; deliberately no timeout.
      S_WAIT: begin
        if (seen_q && !acq_busy) begin
          state_d = S_GAP;
          seen_d  = 1'b0;
          cnt_d   = sh_gap_q;
        end else if (acq_busy) begin
          seen_d = 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          if (shot_idx_q == sh_last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_PON;
            shot_idx_d = shot_idx_q + 1'b1;
            cnt_d      = sh_pon_q;
            pon_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a start sampled while idle.
    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      seen_d     = 1'b0;
      shot_idx_d = '0;
      pon_d      = 1'b0;
      poff_d     = 1'b0;
      en_acq_d   = 1'b0;
      done_d     = 1'b0;
    end

    // busy is registered from the next state, so it falls on the done edge.
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      pon_q      <= 1'b0;
      poff_q     <= 1'b0;
      en_acq_q   <= 1'b0;
      busy_q     <= 1'b0;
      shot_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      pon_q      <= pon_d;
      poff_q     <= poff_d;
      en_acq_q   <= en_acq_d;
      busy_q     <= busy_d;
      shot_idx_q <= shot_idx_d;
      done_q     <= done_d;
    end
  end

  // NOTE: the shadow registers are always written on the edge leaving idle
  // before anything reads them, so they carry no reset.
  always_ff @(posedge clk) begin
    sh_pon_q   <= sh_pon_d;
    sh_poff_q  <= sh_poff_d;
    sh_delay_q <= sh_delay_d;
    sh_gap_q   <= sh_gap_d;
    sh_last_q  <= sh_last_d;
  end

  assign pon            = pon_q;
  assign poff           = poff_q;
  assign en_acquisition = en_acq_q;
  assign busy           = busy_q;
  assign shot_idx       = shot_idx_q;
  assign done           = done_q;

endmodule
